sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like bus between the instruction-fetch requester and the data-access requester of the 5-stage MIPS core.
- Prepares the move from the separate inst_sram/data_sram ports to a single bridge-facing port.
- Allows one outstanding transaction at a time.
- Data side has priority, with a starvation guard for instruction fetch.

Parameters:
ADDR_W, 32, address width of all requester and bus address ports
DATA_W, 32, data width of wdata/rdata ports
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win (range 1..7)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset (derived as ~resetn at top level)
inst_req  in  1  instruction requester: request valid
inst_wr  in  1  write flag
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  ADDR_W  byte address
inst_wdata  in  DATA_W  write data
inst_addr_ok  out  1  request accepted
inst_data_ok  out  1  response valid
inst_rdata  out  DATA_W  read data
data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/ADDR_W/DATA_W  data requester, same meanings as inst_*
data_addr_ok, data_data_ok, data_rdata  out  1/1/DATA_W  data requester, same meanings as inst_*
bus_req  out  1  request to shared bus
bus_wr, bus_size, bus_addr, bus_wdata  out  1/2/ADDR_W/DATA_W  muxed request fields
bus_addr_ok  in  1  bus accepted request
bus_data_ok  in  1  bus response valid
bus_rdata  in  DATA_W  bus read data
owner  out  1  current/last granted requester: 0=inst, 1=data
protocol_err  out  1  sticky: bus_data_ok seen with no transaction outstanding

Behaviour:
- Reset state:
  - FSM=IDLE, owner=0, starve_cnt=0, protocol_err=0.
  - All *_addr_ok, *_data_ok and bus_req are 0.
  - bus_* fields are 0.
- FSM states:
  - IDLE: no transaction.
  - HOLD: request presented, not yet accepted.
  - WAIT: accepted, awaiting response.
- IDLE, arbitration (combinational, same cycle):
  - grant=data if data_req and not (inst_req and starve_cnt==STARVE_LIMIT).
  - Otherwise grant=inst if inst_req.
  - bus_req = inst_req | data_req. bus_* fields are muxed from the granted requester.
  - granted_addr_ok = bus_addr_ok. The other requester's addr_ok is 0.
- IDLE transitions:
  - bus_req & bus_addr_ok -> WAIT, owner<=grant.
  - bus_req & !bus_addr_ok -> HOLD, owner<=grant (grant frozen).
- HOLD:
  - bus_req=1, fields muxed from owner, owner's addr_ok = bus_addr_ok.
  - The other requester is never acknowledged.
  - On bus_addr_ok -> WAIT.
- WAIT:
  - bus_req=0.
  - owner's data_ok = bus_data_ok. The other requester's data_ok is 0.
  - On bus_data_ok -> IDLE. The next grant happens at the earliest in the following cycle; no same-cycle back-to-back.
- rdata: inst_rdata and data_rdata are both driven with bus_rdata continuously; only data_ok qualifies them.
- starve_cnt (3-bit), updated at each acceptance (bus_addr_ok while bus_req):
  - Data accepted while inst_req=1: increment, saturating at STARVE_LIMIT.
  - Inst accepted: clear to 0.
  - Data accepted while inst_req=0: clear to 0.
- Requester rules:
  - A requester holds req and its fields stable until its addr_ok.
  - Withdrawing req in HOLD is illegal and need not be handled.
- Latency:
  - Arbitration adds zero cycles.
  - Response adds zero cycles: data_ok is combinational from bus_data_ok.
- Boundary conditions:
  - bus_data_ok in IDLE or HOLD: ignored, no data_ok to either requester, protocol_err<=1 (sticky until rst).
  - bus_addr_ok while bus_req=0: ignored.
  - Simultaneous inst_req & data_req in IDLE: data wins unless the starvation guard is active.
  - rst mid-transaction (HOLD or WAIT): return to IDLE next edge, outstanding response discarded. A late bus_data_ok then sets protocol_err.
  - size/addr alignment is not checked; it is passed through unchanged.

Decomposition:
- Shared package:
  - Localparams for FSM encoding: IDLE=2'd0, HOLD=2'd1, WAIT=2'd2.
  - OWNER_INST=1'b0, OWNER_DATA=1'b1.
  - SIZE_BYTE/HALF/WORD=2'd0/1/2.
- One natural sub-module: sram_like_req_mux, a combinational 2:1 mux of {wr,size,addr,wdata} by select.
- FSM and starvation counter stay in the top.

Test Plan:
- Single inst read: inst_req=1 addr=0xBFC00000 size=2, bus_addr_ok same cycle, bus_data_ok 2 cycles later with rdata=0x3C1D0000 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x3C1D0000 in cycle 2; data_* acks stay 0.
- Simultaneous inst_req and data_req (data write addr=0x80001000 wdata=0xDEADBEEF wr=1), starve_cnt=0 -> data granted first (bus_wr=1, bus_addr=0x80001000); inst granted in the cycle after data's data_ok.
- Starvation guard: inst_req held high, data_req high for 5 requests, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D; starve_cnt returns to 0 after the inst grant.
- Hold: bus_addr_ok low for 3 cycles with data_req granted, inst_req rising in cycle 1 -> bus fields stay at data values; owner=1; inst_addr_ok=0 throughout HOLD.
- Stray response: bus_data_ok=1 in IDLE -> no *_data_ok pulse; protocol_err=1 and stays 1 until rst.
- Reset mid-WAIT: rst=1 for 1 cycle during WAIT, then bus_data_ok -> FSM=IDLE, no data_ok forwarded, protocol_err=1; next inst_req served normally.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the inst/data SRAM-like bus arbiter.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_req_mux.sv
// Selects the request fields of one requester for the shared bus.
module sram_like_req_mux
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    if (sel == OWNER_DATA) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
    end else begin
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wdata = inst_wdata;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates one outstanding SRAM-like transaction between inst fetch and data
// access; data wins unless inst has waited through STARVE_LIMIT data grants.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner,
  output logic              protocol_err
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t            state, state_nx;
  logic [2:0]        starve_cnt;
  logic              grant;
  logic              sel;
  logic              accept;
  logic              mux_wr;
  logic [1:0]        mux_size;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  function automatic logic [2:0] starve_inc(input logic [2:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 3'd1;
  endfunction

  // Grant is only meaningful in IDLE; afterwards the registered owner steers.
  always_comb begin
    grant = OWNER_INST;
    if (data_req && !(inst_req && (starve_cnt == LIMIT)))
      grant = OWNER_DATA;
  end

  assign sel = (state == IDLE) ? grant : owner;

  sram_like_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .sel       (sel),
    .inst_wr   (inst_wr),
    .inst_size (inst_size),
    .inst_addr (inst_addr),
    .inst_wdata(inst_wdata),
    .data_wr   (data_wr),
    .data_size (data_size),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .wr        (mux_wr),
    .size      (mux_size),
    .addr      (mux_addr),
    .wdata     (mux_wdata)
  );

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  always_comb begin
    state_nx     = state;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    // Outputs are held quiet while reset is asserted.
    if (!rst) begin
      case (state)
        IDLE: begin
          bus_req = inst_req | data_req;
          if (bus_req) state_nx = bus_addr_ok ? WAIT : HOLD;
        end
        HOLD: begin
          bus_req = 1'b1;
          if (bus_addr_ok) state_nx = WAIT;
        end
        WAIT: begin
          if (bus_data_ok) begin
            state_nx     = IDLE;
            inst_data_ok = (owner == OWNER_INST);
            data_data_ok = (owner == OWNER_DATA);
          end
        end
        default: state_nx = IDLE;
      endcase
      if (bus_req) begin
        bus_wr       = mux_wr;
        bus_size     = mux_size;
        bus_addr     = mux_addr;
        bus_wdata    = mux_wdata;
        inst_addr_ok = bus_addr_ok && (sel == OWNER_INST);
        data_addr_ok = bus_addr_ok && (sel == OWNER_DATA);
      end
    end
  end

  assign accept = bus_req && bus_addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWNER_INST;
      starve_cnt   <= 3'd0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && bus_req) owner <= grant;
      if (accept) begin
        if ((sel == OWNER_DATA) && inst_req) starve_cnt <= starve_inc(starve_cnt);
        else                                 starve_cnt <= 3'd0;
      end
      if (bus_data_ok && (state != WAIT)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed vector bench for sram_like_arbiter: one table row per clock cycle.
module tb_sram_like_arbiter;

  localparam logic [31:0] I_ADDR  = 32'hBFC0_0000;
  localparam logic [31:0] I_WDATA = 32'h1111_2222;
  localparam logic [31:0] DW_ADDR = 32'h8000_1000;
  localparam logic [31:0] DW_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DR_ADDR = 32'h8000_2000;
  localparam logic [31:0] DR_DATA = 32'h3333_4444;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        owner, protocol_err;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .owner(owner), .protocol_err(protocol_err)
  );

  // dcode: 0 none, 1 data write, 2 data read.
  // ctl: {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, owner, protocol_err}
  // src: expected bus request source, 0 none, 1 inst, 2 data write, 3 data read.
  typedef struct {
    logic        r;
    logic        ireq;
    logic [1:0]  dcode;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic [5:0]  ctl;
    logic [1:0]  src;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    nvec = 0;
  int    nerr = 0;

  task automatic add(input string nm, input logic r, input logic ireq,
                     input logic [1:0] dcode, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic [5:0] ctl, input logic [1:0] src);
    vec_t v;
    v.r = r; v.ireq = ireq; v.dcode = dcode; v.aok = aok; v.dok = dok;
    v.rd = rd; v.ctl = ctl; v.src = src;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  // {bus_req, bus_wr, bus_size, bus_addr, bus_wdata}
  function automatic logic [67:0] exp_bus(input logic [1:0] src);
    case (src)
      2'd1:    return {1'b1, 1'b0, 2'd2, I_ADDR, I_WDATA};
      2'd2:    return {1'b1, 1'b1, 2'd2, DW_ADDR, DW_DATA};
      2'd3:    return {1'b1, 1'b0, 2'd0, DR_ADDR, DR_DATA};
      default: return 68'd0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    rst         = v.r;
    inst_req    = v.ireq;
    data_req    = (v.dcode != 2'd0);
    data_wr     = (v.dcode == 2'd1);
    data_size   = (v.dcode == 2'd1) ? 2'd2 : 2'd0;
    data_addr   = (v.dcode == 2'd1) ? DW_ADDR : DR_ADDR;
    data_wdata  = (v.dcode == 2'd1) ? DW_DATA : DR_DATA;
    bus_addr_ok = v.aok;
    bus_data_ok = v.dok;
    bus_rdata   = v.rd;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic [5:0]  got_ctl;
    logic [67:0] got_bus;
    got_ctl = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, owner, protocol_err};
    got_bus = {bus_req, bus_wr, bus_size, bus_addr, bus_wdata};
    nvec++;
    if (got_ctl !== v.ctl || got_bus !== exp_bus(v.src) ||
        inst_rdata !== v.rd || data_rdata !== v.rd) begin
      nerr++;
      $display("FAIL %s: ctl=%b bus=%h irdata=%h drdata=%h, expected ctl=%b bus=%h rdata=%h",
               nm, got_ctl, got_bus, inst_rdata, data_rdata, v.ctl, exp_bus(v.src), v.rd);
    end
  endtask

  initial begin
    vec_t v;
    inst_wr = 1'b0; inst_size = 2'd2; inst_addr = I_ADDR; inst_wdata = I_WDATA;
    v = '{r:1'b1, ireq:1'b0, dcode:2'd0, aok:1'b0, dok:1'b0, rd:32'h0, ctl:6'b0, src:2'd0};
    drive(v);
    repeat (2) @(posedge clk);

    //   name        rst ireq dc aok dok rdata          ctl          src
    add("reset",      1, 1, 1, 0, 0, 32'h0,        6'b0000_00, 0);
    add("i_acc",      0, 1, 0, 1, 0, 32'h0,        6'b1000_00, 1);
    add("i_wait",     0, 0, 0, 0, 0, 32'h0,        6'b0000_00, 0);
    add("i_resp",     0, 0, 0, 0, 1, 32'h3C1D0000, 6'b0100_00, 0);
    add("sim_d",      0, 1, 1, 1, 0, 32'h0,        6'b0010_00, 2);
    add("sim_wait",   0, 1, 0, 0, 0, 32'h0,        6'b0000_10, 0);
    add("sim_dok",    0, 1, 0, 0, 1, 32'hCAFEF00D, 6'b0001_10, 0);
    add("sim_i",      0, 1, 0, 1, 0, 32'h0,        6'b1000_10, 1);
    add("sim_iok",    0, 0, 0, 0, 1, 32'h12345678, 6'b0100_00, 0);
    add("st_d1",      0, 1, 2, 1, 0, 32'h0,        6'b0010_00, 3);
    add("st_d1r",     0, 1, 2, 0, 1, 32'h000000D1, 6'b0001_10, 0);
    add("st_d2",      0, 1, 2, 1, 0, 32'h0,        6'b0010_10, 3);
    add("st_d2r",     0, 1, 2, 0, 1, 32'h000000D2, 6'b0001_10, 0);
    add("st_d3",      0, 1, 2, 1, 0, 32'h0,        6'b0010_10, 3);
    add("st_d3r",     0, 1, 2, 0, 1, 32'h000000D3, 6'b0001_10, 0);
    add("st_d4",      0, 1, 2, 1, 0, 32'h0,        6'b0010_10, 3);
    add("st_d4r",     0, 1, 2, 0, 1, 32'h000000D4, 6'b0001_10, 0);
    add("st_i",       0, 1, 2, 1, 0, 32'h0,        6'b1000_10, 1);
    add("st_ir",      0, 1, 2, 0, 1, 32'h0000001F, 6'b0100_00, 0);
    add("st_d5",      0, 1, 2, 1, 0, 32'h0,        6'b0010_00, 3);
    add("st_d5r",     0, 1, 2, 0, 1, 32'h000000D5, 6'b0001_10, 0);
    add("st_d6",      0, 1, 2, 1, 0, 32'h0,        6'b0010_10, 3);
    add("st_d6r",     0, 1, 2, 0, 1, 32'h000000D6, 6'b0001_10, 0);
    add("hold0",      0, 0, 1, 0, 0, 32'h0,        6'b0000_10, 2);
    add("hold1",      0, 1, 1, 0, 0, 32'h0,        6'b0000_10, 2);
    add("hold2",      0, 1, 1, 0, 0, 32'h0,        6'b0000_10, 2);
    add("hold_acc",   0, 1, 1, 1, 0, 32'h0,        6'b0010_10, 2);
    add("hold_dok",   0, 1, 0, 0, 1, 32'h00000077, 6'b0001_10, 0);
    add("hold_i",     0, 1, 0, 1, 0, 32'h0,        6'b1000_10, 1);
    add("hold_iok",   0, 0, 0, 0, 1, 32'hAABBCCDD, 6'b0100_00, 0);
    add("aok_idle",   0, 0, 0, 1, 0, 32'h0,        6'b0000_00, 0);
    add("stray",      0, 0, 0, 0, 1, 32'h00000055, 6'b0000_00, 0);
    add("sticky",     0, 0, 0, 0, 0, 32'h0,        6'b0000_01, 0);
    add("err_i",      0, 1, 0, 1, 0, 32'h0,        6'b1000_01, 1);
    add("err_iok",    0, 0, 0, 0, 1, 32'h00000042, 6'b0100_01, 0);
    add("rst_clr",    1, 0, 0, 0, 0, 32'h0,        6'b0000_01, 0);
    add("rw_acc",     0, 1, 0, 1, 0, 32'h0,        6'b1000_00, 1);
    add("rw_rst",     1, 0, 0, 0, 0, 32'h0,        6'b0000_00, 0);
    add("rw_late",    0, 0, 0, 0, 1, 32'h00000011, 6'b0000_00, 0);
    add("rw_i",       0, 1, 0, 1, 0, 32'h0,        6'b1000_01, 1);
    add("rw_iok",     0, 0, 0, 0, 1, 32'h00000099, 6'b0100_01, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check(names[i], vecs[i]);
    end

    // Idle tail: protocol_err stays set while bus_addr_ok toggles with no request.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v = '{r:1'b0, ireq:1'b0, dcode:2'd0, aok:k[0], dok:1'b0,
            rd:32'h5000_0000 + 32'(k), ctl:6'b0000_01, src:2'd0};
      drive(v);
      #1;
      check($sformatf("tail%0d", k), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
